engine_config_capture_multi: RTL and testbench

//  Per-engine setup-word capture: filters the engine's window of CU/engine setup response words,

---
 rtl/engine_config_capture_multi.sv | 210 +++++++++++++++++++++
 tb/tb_engine_config_capture_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_config_capture_multi.sv
// Per-engine setup-word capture: filters this engine's window of setup words, assembles
// NUM_FIELDS config fields into a record and queues records in a first-word-fall-through FIFO.
module engine_config_capture_multi #(
  parameter int ID_RELATIVE      = 0,
  parameter int ENGINE_SEQ_WIDTH = 16,
  parameter int NUM_FIELDS       = 4,
  parameter int FIELD_W          = 32,
  parameter int ADDR_W           = 64,
  parameter int FIFO_DEPTH       = 16,
  parameter int PROG_THRESH      = 8
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic                             in_setup,
  input  logic [ADDR_W-1:0]                in_offset,
  input  logic [5:0]                       in_shift,
  input  logic [FIELD_W-1:0]               in_data,
  output logic                             cfg_valid,
  input  logic                             cfg_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0]    cfg_fields,
  output logic [15:0]                      cfg_rec_id,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             prog_full,
  output logic                             busy,
  output logic                             err_order,
  output logic                             err_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(ENGINE_SEQ_WIDTH);
  localparam int REC_W = NUM_FIELDS * FIELD_W;
  localparam logic [ADDR_W-1:0] SEQ_MIN  = ADDR_W'(ID_RELATIVE * ENGINE_SEQ_WIDTH);
  localparam logic [ADDR_W-1:0] SEQ_SPAN = ADDR_W'(ENGINE_SEQ_WIDTH);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ENGINE_SEQ_WIDTH - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  logic               r_vld_p1;
  logic               r_setup_p1;
  logic [ADDR_W-1:0]  r_offset_p1;
  logic [5:0]         r_shift_p1;
  logic [FIELD_W-1:0] r_data_p1;

  state_t             r_state, w_state_nx;
  logic [IDX_W-1:0]   r_expect, w_expect_nx;
  logic [REC_W-1:0]   r_fields, w_fields_nx;
  logic [15:0]        r_rec_cnt;
  logic               r_err_order, r_err_ovf;

  logic [REC_W-1:0]   r_mem_f  [FIFO_DEPTH];
  logic [15:0]        r_mem_id [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [ADDR_W-1:0]  w_seq, w_rel;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hit, w_store, w_restart, w_complete, w_err_set;
  logic               w_pop, w_push, w_has_room;

  // Stage 1: register the raw word; all decisions below are taken on this copy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld_p1    <= 1'b0;
      r_setup_p1  <= 1'b0;
      r_offset_p1 <= '0;
      r_shift_p1  <= '0;
      r_data_p1   <= '0;
    end else begin
      r_vld_p1    <= in_valid & ~clear;
      r_setup_p1  <= in_setup;
      r_offset_p1 <= in_offset;
      r_shift_p1  <= in_shift;
      r_data_p1   <= in_data;
    end
  end

  // Window hit: the wrapped difference is below the span only when MIN <= seq < MAX
  assign w_seq = r_offset_p1 >> r_shift_p1;
  assign w_rel = w_seq - SEQ_MIN;
  assign w_idx = IDX_W'(w_rel);
  assign w_hit = r_vld_p1 & r_setup_p1 & (w_rel < SEQ_SPAN);

  always_comb begin
    w_state_nx  = r_state;
    w_expect_nx = r_expect;
    w_fields_nx = r_fields;
    w_store     = 1'b0;
    w_restart   = 1'b0;
    w_complete  = 1'b0;
    w_err_set   = 1'b0;
    if (w_hit) begin
      case (r_state)
        S_IDLE: begin
          if (w_idx == '0) w_restart = 1'b1;
          else             w_err_set = 1'b1;
        end
        S_COLLECT: begin
          if (w_idx == r_expect) begin
            w_store = 1'b1;
            if (w_idx == IDX_LAST) begin
              w_complete  = 1'b1;
              w_expect_nx = '0;
              w_state_nx  = S_IDLE;
            end else begin
              w_expect_nx = r_expect + IDX_W'(1);
            end
          end else if (w_idx == '0) begin
            w_err_set = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_err_set   = 1'b1;
            w_expect_nx = '0;
            w_state_nx  = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
    if (w_restart) begin
      w_fields_nx = '0;
      w_store     = 1'b1;
      w_expect_nx = IDX_W'(1);
      w_state_nx  = S_COLLECT;
    end
    // Window indices at or beyond NUM_FIELDS advance the sequence but carry no field
    if (w_store) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        if (w_idx == IDX_W'(k)) w_fields_nx[k*FIELD_W +: FIELD_W] = r_data_p1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state  <= S_IDLE;
      r_expect <= '0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_expect <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_expect <= w_expect_nx;
    end
  end

  assign w_pop      = cfg_valid & cfg_ready;
  assign w_has_room = (r_count < CNT_W'(FIFO_DEPTH)) | w_pop;
  assign w_push     = w_complete & w_has_room & ~clear;

  // Record assembly, record numbering and sticky error flags
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_fields    <= '0;
      r_rec_cnt   <= '0;
      r_err_order <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_fields <= w_fields_nx;
      if (clear) begin
        r_err_order <= 1'b0;
        r_err_ovf   <= 1'b0;
      end else begin
        if (w_complete) r_rec_cnt <= r_rec_cnt + 16'd1;
        if (w_err_set) r_err_order <= 1'b1;
        if (w_complete && !w_has_room) r_err_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_mem_f[r_wr_ptr]  <= w_fields_nx;
      r_mem_id[r_wr_ptr] <= r_rec_cnt;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is gated so the record outputs read zero whenever the queue is empty
  assign cfg_valid    = (r_count != '0);
  assign cfg_fields   = cfg_valid ? r_mem_f[r_rd_ptr]  : '0;
  assign cfg_rec_id   = cfg_valid ? r_mem_id[r_rd_ptr] : '0;
  assign fifo_count   = r_count;
  assign prog_full    = (r_count >= CNT_W'(PROG_THRESH));
  assign busy         = (r_state == S_COLLECT);
  assign err_order    = r_err_order;
  assign err_overflow = r_err_ovf;

endmodule

// File: tb/tb_engine_config_capture_multi.sv
// Randomised bench for engine_config_capture_multi (engine slot 1, window seq 16..31) against
// a cycle-stepped queue model of records, window progress and sticky errors.
module tb_engine_config_capture_multi;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_setup = 1'b0;
  logic [63:0]  in_offset = '0;
  logic [5:0]   in_shift = '0;
  logic [31:0]  in_data = '0;
  logic         cfg_valid;
  logic         cfg_ready = 1'b0;
  logic [127:0] cfg_fields;
  logic [15:0]  cfg_rec_id;
  logic [4:0]   fifo_count;
  logic         prog_full, busy, err_order, err_overflow;

  engine_config_capture_multi #(
    .ID_RELATIVE(1), .ENGINE_SEQ_WIDTH(16), .NUM_FIELDS(4), .FIELD_W(32),
    .ADDR_W(64), .FIFO_DEPTH(16), .PROG_THRESH(8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear),
    .in_valid(in_valid), .in_setup(in_setup), .in_offset(in_offset),
    .in_shift(in_shift), .in_data(in_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fields(cfg_fields),
    .cfg_rec_id(cfg_rec_id), .fifo_count(fifo_count), .prog_full(prog_full),
    .busy(busy), .err_order(err_order), .err_overflow(err_overflow)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_ready = 1'b0;

  typedef struct {
    logic [127:0] f;
    logic [15:0]  id;
  } rec_t;

  rec_t         m_q[$];
  int           m_next;      // next window index the engine expects; 0 = waiting for a start
  logic [127:0] m_part;
  logic [15:0]  m_cnt;
  bit           m_eo, m_eov;
  bit           d_hit;
  int           d_idx;
  logic [31:0]  d_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_next = 0;
    m_part = '0;
    m_cnt  = '0;
    m_eo   = 1'b0;
    m_eov  = 1'b0;
    d_hit  = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_step();
    bit          pop, full, push;
    logic [63:0] seq;
    rec_t        r;
    pop  = (m_q.size() > 0) && cfg_ready;
    full = (m_q.size() >= 16);
    push = 1'b0;
    if (clear) begin
      m_q.delete();
      m_next = 0;
      m_eo   = 1'b0;
      m_eov  = 1'b0;
      d_hit  = 1'b0;
      return;
    end
    if (d_hit) begin
      if (d_idx == m_next) begin
        if (d_idx == 0) m_part = '0;
        if (d_idx < 4) m_part[d_idx*32 +: 32] = d_data;
        m_next++;
        if (d_idx == 15) begin
          push   = 1'b1;
          m_next = 0;
        end
      end else if (d_idx == 0) begin
        m_eo   = 1'b1;
        m_part = '0;
        m_part[31:0] = d_data;
        m_next = 1;
      end else begin
        m_eo   = 1'b1;
        m_next = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) begin
        r.f  = m_part;
        r.id = m_cnt;
        m_q.push_back(r);
      end else begin
        m_eov = 1'b1;
      end
      m_cnt = m_cnt + 16'd1;
    end
    seq    = in_offset >> in_shift;
    d_hit  = in_valid && in_setup && (seq >= 64'd16) && (seq < 64'd32);
    d_idx  = int'(seq) - 16;
    d_data = in_data;
  endtask

  task automatic check_outputs();
    chk("cfg_valid", 128'(cfg_valid), 128'(m_q.size() > 0));
    chk("fifo_count", 128'(fifo_count), 128'(m_q.size()));
    chk("prog_full", 128'(prog_full), 128'(m_q.size() >= 8));
    chk("busy", 128'(busy), 128'(m_next != 0));
    chk("err_order", 128'(err_order), 128'(m_eo));
    chk("err_overflow", 128'(err_overflow), 128'(m_eov));
    if (m_q.size() > 0) begin
      chk("cfg_fields", cfg_fields, m_q[0].f);
      chk("cfg_rec_id", 128'(cfg_rec_id), 128'(m_q[0].id));
    end
  endtask

  task automatic tick();
    if (rnd_ready) cfg_ready = 1'($urandom_range(0, 1));
    @(posedge ap_clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic word(input int seq, input logic [31:0] data, input bit setup);
    int sh;
    sh        = $urandom_range(0, 5);
    in_shift  = 6'(sh);
    in_offset = (64'(seq) << sh) | 64'($urandom_range(0, (1 << sh) - 1));
    in_setup  = setup;
    in_valid  = 1'b1;
    in_data   = data;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic window(input logic [31:0] base, input int err_pct);
    int seq;
    for (int i = 0; i < 16; i++) begin
      seq = 16 + i;
      if ($urandom_range(0, 99) < err_pct) seq = $urandom_range(0, 40);
      word(seq, base + 32'(i), 1'b1);
      if (err_pct > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_cfg_valid", 128'(cfg_valid), 128'(0));
    chk("rst_fifo_count", 128'(fifo_count), 128'(0));
    chk("rst_prog_full", 128'(prog_full), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err_order", 128'(err_order), 128'(0));
    chk("rst_err_overflow", 128'(err_overflow), 128'(0));
    chk("rst_cfg_fields", cfg_fields, 128'(0));
    chk("rst_cfg_rec_id", 128'(cfg_rec_id), 128'(0));
    model_reset();
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    // T1: one clean window, record visible two cycles after its last word
    do_reset();
    cfg_ready = 1'b1;
    window(32'hA0, 0);
    chk("t1_latency_early", 128'(cfg_valid), 128'(0));
    tick();
    chk("t1_valid", 128'(cfg_valid), 128'(1));
    chk("t1_fields", cfg_fields, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_rec_id", 128'(cfg_rec_id), 128'(0));
    chk("t1_errs", 128'({err_order, err_overflow}), 128'(0));
    tick();
    chk("t1_popped", 128'(cfg_valid), 128'(0));

    // T2: skipped index aborts the record; the next clean window is record 0
    do_reset();
    cfg_ready = 1'b0;
    word(16, 32'h1, 1'b1);
    word(17, 32'h2, 1'b1);
    word(19, 32'h3, 1'b1);
    idle(1);
    chk("t2_err_order", 128'(err_order), 128'(1));
    chk("t2_no_record", 128'(cfg_valid), 128'(0));
    window(32'h50, 0);
    idle(2);
    chk("t2_rec_id", 128'(cfg_rec_id), 128'(0));
    chk("t2_count", 128'(fifo_count), 128'(1));

    // T3: seventeen windows into a sixteen-deep queue, then drain
    do_reset();
    cfg_ready = 1'b0;
    for (int w = 0; w < 17; w++) window(32'(w * 16), 0);
    idle(2);
    chk("t3_count", 128'(fifo_count), 128'(16));
    chk("t3_prog_full", 128'(prog_full), 128'(1));
    chk("t3_overflow", 128'(err_overflow), 128'(1));
    cfg_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_id", 128'(cfg_rec_id), 128'(i));
      tick();
    end
    chk("t3_drained", 128'(cfg_valid), 128'(0));

    // T4: non-setup words and out-of-window sequence numbers are ignored
    do_reset();
    for (int i = 0; i < 16; i++) word(16 + i, 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) word(i, 32'(i), 1'b1);
    for (int i = 0; i < 16; i++) word(32 + i, 32'(i), 1'b1);
    in_offset = 64'hFFFF_FFFF_FFFF_FFF0;
    in_shift  = 6'd0;
    in_setup  = 1'b1;
    in_valid  = 1'b1;
    tick();
    idle(2);
    chk("t4_busy", 128'(busy), 128'(0));
    chk("t4_err", 128'(err_order), 128'(0));
    chk("t4_valid", 128'(cfg_valid), 128'(0));

    // T5: clear mid-window with queued records; record numbering survives
    do_reset();
    cfg_ready = 1'b1;
    window(32'h10, 0);
    idle(2);
    cfg_ready = 1'b0;
    for (int w = 0; w < 3; w++) window(32'h100 * 32'(w + 1), 0);
    for (int i = 0; i < 8; i++) word(16 + i, 32'(i), 1'b1);
    chk("t5_busy_before", 128'(busy), 128'(1));
    do_clear();
    chk("t5_valid", 128'(cfg_valid), 128'(0));
    chk("t5_count", 128'(fifo_count), 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    window(32'h77, 0);
    idle(2);
    chk("t5_rec_id", 128'(cfg_rec_id), 128'(4));

    // T6: reset with a full queue and a partial window
    do_reset();
    cfg_ready = 1'b0;
    for (int w = 0; w < 16; w++) window(32'(w), 0);
    for (int i = 0; i < 5; i++) word(16 + i, 32'(i), 1'b1);
    do_reset();
    window(32'hC0, 0);
    idle(2);
    chk("t6_rec_id", 128'(cfg_rec_id), 128'(0));
    chk("t6_fields", cfg_fields, 128'h000000C3_000000C2_000000C1_000000C0);

    // Random traffic: dirty windows, junk, random ready and occasional clear
    do_reset();
    rnd_ready = 1'b1;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    for (int i = 0; i < 4; i++) word($urandom_range(0, 47), $urandom, 1'($urandom_range(0, 1)));
        2:       if ($urandom_range(0, 2) == 0) do_clear(); else idle(3);
        3, 4, 5: window($urandom, 10);
        default: window($urandom, 0);
      endcase
    end
    rnd_ready = 1'b0;
    cfg_ready = 1'b1;
    idle(20);
    chk("rnd_drained", 128'(cfg_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
